// File: rtl/uart_alu_ctrl.sv
// Packet controller between the uart_rx and uart_tx byte streams. It parses
// framed command packets, then runs a 32-bit ADD/XOR accumulation, echoes the
// payload, or discards a malformed packet.
module uart_alu_ctrl #(
    parameter logic [7:0] ECHO_OP = 8'hEC,
    parameter logic [7:0] ADD_OP  = 8'hA1,
    parameter logic [7:0] XOR_OP  = 8'hB2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy,
    output logic       err_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr1,
        StLenLo,
        StLenHi,
        StAccum,
        StResult,
        StEcho,
        StDrain
    } state_e;

    state_e      state_q;
    logic [7:0]  op_q;
    logic [7:0]  len_lo_q;
    logic [15:0] rem_q;
    logic [31:0] acc_q;
    logic [23:0] sreg_q;
    logic [1:0]  idx_q;
    logic [7:0]  m_tdata_q;
    logic        m_tvalid_q;
    logic        err_q;
    logic        done_q;

    logic        s_hs;
    logic        m_hs;
    logic [15:0] len_w;
    logic [15:0] rem_w;
    logic        op_is_alu;
    logic        len_ok;
    logic [31:0] word_w;
    logic [31:0] acc_upd_w;
    logic [1:0]  idx_inc_w;
    logic [7:0]  res_byte_w;

    assign s_hs       = s_axis_tvalid && s_axis_tready;
    assign m_hs       = m_tvalid_q && m_axis_tready;
    // LEN is complete only in the cycle its high byte is on the bus
    assign len_w      = {s_axis_tdata, len_lo_q};
    assign rem_w      = (len_w < 16'd4) ? 16'd0 : (len_w - 16'd4);
    assign op_is_alu  = (op_q == ADD_OP) || (op_q == XOR_OP);
    assign len_ok     = (len_w >= 16'd8) && (len_w[1:0] == 2'b00);
    // Fourth byte of an operand is the MSB; the lower three sit in sreg_q
    assign word_w     = {s_axis_tdata, sreg_q};
    assign acc_upd_w  = (op_q == ADD_OP) ? (acc_q + word_w) : (acc_q ^ word_w);
    assign idx_inc_w  = idx_q + 2'd1;
    assign res_byte_w = acc_q[{idx_inc_w, 3'b000} +: 8];

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign err_o         = err_q;
    assign done_o        = done_q;
    assign busy          = (state_q != StIdle);

    // Input-side ready: echo only takes a byte when the output slot frees up
    // and payload remains, so the next packet's opcode is never swallowed.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle, StHdr1, StLenLo, StLenHi, StAccum, StDrain: s_axis_tready = 1'b1;
                StEcho:  s_axis_tready = (rem_q != 16'd0) && (!m_tvalid_q || m_axis_tready);
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    // Packet FSM with registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= 8'd0;
            len_lo_q   <= 8'd0;
            rem_q      <= 16'd0;
            acc_q      <= 32'd0;
            sreg_q     <= 24'd0;
            idx_q      <= 2'd0;
            m_tdata_q  <= 8'd0;
            m_tvalid_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (s_hs) begin
                        op_q    <= s_axis_tdata;
                        state_q <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (s_hs) state_q <= StLenLo;
                end
                StLenLo: begin
                    if (s_hs) begin
                        len_lo_q <= s_axis_tdata;
                        state_q  <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (s_hs) begin
                        rem_q <= rem_w;
                        if (len_w < 16'd4) begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end else if (op_q == ECHO_OP) begin
                            if (rem_w == 16'd0) begin
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StEcho;
                            end
                        end else if (op_is_alu && len_ok) begin
                            acc_q   <= 32'd0;
                            idx_q   <= 2'd0;
                            state_q <= StAccum;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= (rem_w == 16'd0) ? StIdle : StDrain;
                        end
                    end
                end
                StAccum: begin
                    if (s_hs) begin
                        rem_q <= rem_q - 16'd1;
                        idx_q <= idx_inc_w;
                        if (idx_q == 2'd3) begin
                            acc_q <= acc_upd_w;
                        end else begin
                            sreg_q <= {s_axis_tdata, sreg_q[23:8]};
                        end
                        // Length check guarantees the last byte closes an operand
                        if (rem_q == 16'd1) begin
                            m_tdata_q  <= acc_upd_w[7:0];
                            m_tvalid_q <= 1'b1;
                            state_q    <= StResult;
                        end
                    end
                end
                StResult: begin
                    if (m_hs) begin
                        if (idx_q == 2'd3) begin
                            m_tvalid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            m_tdata_q <= res_byte_w;
                            idx_q     <= idx_inc_w;
                        end
                    end
                end
                StEcho: begin
                    if (s_hs) begin
                        m_tdata_q  <= s_axis_tdata;
                        m_tvalid_q <= 1'b1;
                        rem_q      <= rem_q - 16'd1;
                    end else if (m_hs) begin
                        m_tvalid_q <= 1'b0;
                        if (rem_q == 16'd0) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                StDrain: begin
                    if (s_hs) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Packet controller that sits between the `uart_rx` master stream and the `uart_tx` slave stream in the iCE40 UART ALU top level. It parses framed command packets from the host byte stream and sequences a 32-bit accumulate datapath (ADD or XOR) or an echo path. It returns results to the host over the TX stream, applying backpressure to both sides.

## Interface

Parameters:

- `ECHO_OP`, 8'hEC, opcode for echo.
- `ADD_OP`, 8'hA1, opcode for 32-bit sum of operands, mod 2^32.
- `XOR_OP`, 8'hB2, opcode for 32-bit XOR of operands.

Ports:

- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  8  byte from `uart_rx`.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tready`  out  1  controller accepts byte.
- `m_axis_tdata`  out  8  byte to `uart_tx`.
- `m_axis_tvalid`  out  1  output byte valid.
- `m_axis_tready`  in  1  `uart_tx` accepts byte.
- `busy`  out  1  high whenever state != IDLE.
- `err_o`  out  1  one-cycle pulse on a malformed or unknown packet.
- `done_o`  out  1  one-cycle pulse when a packet fully completes, including output drain.

## Operation

Packet format, one byte per transfer:

- Byte 0: opcode.
- Byte 1: reserved, ignored.
- Bytes 2–3: LEN, little-endian, total packet bytes including the 4-byte header.
- Bytes 4..LEN-1: payload. REM = LEN-4 counts payload bytes still to be consumed.

States:

- **IDLE**: `s_axis_tready`=1. Accepting a byte latches the opcode → HDR1.
- **HDR1**: accepts the reserved byte → LEN_LO.
- **LEN_LO**: accepts the LEN low byte → LEN_HI.
- **LEN_HI**: accepts the LEN high byte, then dispatches on the edge that accepts it:
  - LEN<4: `err_o` pulse → IDLE; no further bytes consumed.
  - ECHO_OP, LEN==4: `done_o` pulse → IDLE; nothing is sent.
  - ECHO_OP, LEN>4 → ECHO.
  - ADD_OP or XOR_OP with LEN≥8 and LEN[1:0]==0: acc←0, byte index←0 → ACCUM.
  - ADD_OP or XOR_OP failing the length check, or any other opcode with REM>0: `err_o` pulse → DRAIN.
  - Any other opcode with REM==0: `err_o` pulse → IDLE.
- **ACCUM**: `s_axis_tready`=1.
  - Bytes are assembled little-endian into a 24-bit shift register.
  - On the 4th byte of each operand, word = {byte, sreg[23:0]} and acc ← acc+word (ADD) or acc^word (XOR), on the same edge.
  - REM decrements per byte. When REM reaches 0 → RESULT.
- **RESULT**: `s_axis_tready`=0. Sends acc[7:0], acc[15:8], acc[23:16], acc[31:24] in that order.
  - Each byte advances only on `m_axis_tvalid && m_axis_tready`.
  - After the 4th transfer: `done_o` pulse → IDLE.
- **ECHO**: single-entry output register.
  - `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`.
  - On accept: `m_axis_tdata`←byte, `m_axis_tvalid`←1, REM decrements.
  - `m_axis_tvalid` clears on an output handshake with no new accept.
  - Exit when REM==0 and the register has emptied: `done_o` pulse → IDLE.
- **DRAIN**: `s_axis_tready`=1. Discards REM bytes, then → IDLE. `done_o` is not pulsed.

Arithmetic and widths:

- LEN and REM are 16 bits.
- acc is 32 bits; overflow wraps with no flag.
- Bytes arriving in IDLE are always treated as opcodes; no resync byte exists.

## Timing

- Reset values: `s_axis_tready`=0 while `rst` is high, and 1 in the first cycle after (IDLE). `m_axis_tvalid`=0, `m_axis_tdata`=0, `busy`=0, `err_o`=0, `done_o`=0. State=IDLE, acc=0, REM=0.
- Header throughput: one byte per cycle; no bubbles between header and payload.
- ADD/XOR latency: the last operand byte is accepted at edge N. `m_axis_tvalid`=1 with acc[7:0] is visible in the cycle after edge N.
- RESULT with `m_axis_tready` held high: 4 cycles, then IDLE. IDLE may accept the next opcode in the cycle after `done_o`.
- ECHO pass-through: one cycle of latency, sustaining 1 byte/cycle with `m_axis_tready`=1.
- `m_axis_tdata` is held stable while `m_axis_tvalid` && !`m_axis_tready`.
- `err_o` and `done_o` are registered and high for exactly one cycle.
- `rst` asserted in any state: the next edge forces IDLE and drops `m_axis_tvalid` with no further handshake. A partial packet is lost.

## Test plan

- **ADD**: A1 00 0C 00 02 00 00 00 FF FF FF FF → TX 01 00 00 00; `done_o` once; `err_o` never.
- **XOR**: B2 00 0C 00 78 56 34 12 00 00 FF FF → TX 78 56 CB ED.
- **ECHO with backpressure**: EC 00 07 00 11 22 33 while `m_axis_tready` toggles 1,0,0,1 → TX 11 22 33 in order, no drops or duplicates; `s_axis_tready` low while the output register is full and not ready.
- **Bad length**: A1 00 0A 00 followed by 6 bytes → `err_o` pulse; all 6 bytes drained; no TX. A following valid ADD packet then completes correctly.
- **Unknown opcode**: 55 00 06 00 AA BB → `err_o`; 2 bytes drained; IDLE.
- **Reset mid-RESULT**: assert `rst` after 2 of 4 result bytes are sent → next cycle `m_axis_tvalid`=0, `busy`=0. A new ADD packet produces a correct result.
